wb_stage: RTL
=============

Name: wb_stage

Overview:
- Write-back stage directly upstream of the register file; sole driver of the register file write port (write enable, write address, write data).
- Merges single-cycle ALU results with variable-latency data-memory load returns.
- Tracks one outstanding load, resolves write-port collisions, and raises a stall to the decode/issue stage on load-use hazards.

Parameters:
DW, 8, data width of the register file and write data.
AW, 3, register address width; 2**AW architectural registers.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
alu_valid  input  1  ALU result valid this cycle.
alu_dst  input  AW  ALU destination register.
alu_data  input  DW  ALU result.
ld_req  input  1  load issued this cycle; destination is ld_dst.
ld_dst  input  AW  load destination register.
mem_rvalid  input  1  memory read data valid (one-cycle pulse).
mem_rdata  input  DW  memory read data.
rd_addrA  input  AW  operand A address being read by decode.
rd_addrB  input  AW  operand B address being read by decode.
wr_en  output  1  register file write enable (registered).
wr_addr  output  AW  register file write address (registered).
wr_data  output  DW  register file write data (registered).
stall  output  1  hold decode/issue this cycle (combinational).
ld_busy  output  1  a load is outstanding or held (registered).
protocol_err  output  1  one-cycle pulse on an illegal handshake (registered).

Behaviour:
- Interface:
  - One clock: clk. Reset rst_n is asynchronous, active-low.
  - While rst_n is low: FSM is IDLE; wr_en, wr_addr, wr_data, ld_busy and protocol_err are all 0; captured destination, hold data and kill bit are cleared.
- Write port latency:
  - wr_* are asserted exactly 1 cycle after the winning source event.
  - At most one write per cycle.
- FSM states: IDLE, WAIT (load outstanding), HOLD (load data captured, waiting for the write port).
- IDLE:
  - alu_valid: write alu_dst/alu_data next cycle.
  - ld_req: capture ld_dst into ld_dst_q, clear kill, go to WAIT.
  - alu_valid and ld_req together are legal; both take effect.
- WAIT:
  - mem_rvalid with alu_valid low: write ld_dst_q/mem_rdata next cycle (unless kill), go to IDLE.
  - mem_rvalid with alu_valid high: ALU wins the write port; capture mem_rdata into hold, go to HOLD.
- HOLD:
  - alu_valid low: write hold data (unless kill), go to IDLE.
  - alu_valid high: ALU wins again; stay in HOLD.
- WAW kill: in WAIT or HOLD, alu_valid with alu_dst equal to ld_dst_q sets kill. On completion the load skips its register write, but the FSM still returns to IDLE.
- Illegal events (each ignored, protocol_err pulses next cycle):
  - ld_req in WAIT or HOLD.
  - mem_rvalid in IDLE or HOLD.
- ld_busy is 1 in WAIT and HOLD.
- stall is high when any of the following holds:
  - state is WAIT and (rd_addrA equals ld_dst_q or rd_addrB equals ld_dst_q);
  - state is HOLD (any read is stalled);
  - bypass-disabled case (see Optional Feature).
- stall never depends on alu_valid, which keeps the path free of combinational loops.
- Reset mid-operation: an outstanding load is dropped. A memory return arriving after reset lands in IDLE and flags protocol_err.

Optional Feature:
WB_BYPASS_EN
- Defined:
  - Adds outputs fwdA_en and fwdB_en (1 bit each, combinational).
  - fwdA_en = wr_en and wr_addr equals rd_addrA; likewise fwdB_en for rd_addrB.
  - Decode muxes wr_data in place of the register file read data.
  - No extra stall is generated for this case.
- Undefined:
  - fwd ports are absent.
  - stall is additionally asserted when wr_en is high and wr_addr equals rd_addrA or rd_addrB, because register file reads are combinational and would return the stale value in the write cycle.

Decomposition:
- Package wb_pkg holds:
  - DW and AW defaults;
  - wb_state_t enum {IDLE, WAIT, HOLD};
  - the register-address typedef;
  - the data typedef.
- One sub-module, wb_hazard: purely combinational comparator producing stall (and the fwd enables when bypass is compiled in) from state, ld_dst_q, wr_en/wr_addr and the read addresses. All sequential logic stays in wb_stage.

Test Plan:
- ALU only: alu_valid=1, alu_dst=3, alu_data=8'hA5 -> next cycle wr_en=1, wr_addr=3, wr_data=8'hA5; stall=0.
- Load, latency 4: ld_req, ld_dst=5; mem_rvalid with 8'h3C four cycles later -> ld_busy=1 and stall=1 while rd_addrA=5 during the wait; wr_en with addr 5, data 8'h3C one cycle after mem_rvalid; ld_busy=0 afterwards.
- Collision: load to reg 2 pending; mem_rvalid=8'h11 in the same cycle as alu_valid (dst 6, data 8'h22) -> next cycle write 6/8'h22, then write 2/8'h11; HOLD lasts 1 cycle and stall=1 during it.
- WAW kill: load to reg 4 pending; alu writes reg 4 with 8'h77; memory then returns 8'h99 -> only 4/8'h77 is written, no write of 8'h99, FSM returns to IDLE.
- Protocol and reset: mem_rvalid in IDLE -> protocol_err pulse, no write. Drop rst_n while in WAIT -> outputs 0 immediately; a later mem_rvalid -> protocol_err, no write.
- Bypass: wr_en to reg 1 while rd_addrB=1 -> with WB_BYPASS_EN, fwdB_en=1 and stall=0; without it, stall=1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths, FSM state encoding and register-file typedefs for the write-back stage.
package wb_pkg;

  localparam int WB_DW = 8;
  localparam int WB_AW = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } wb_state_t;

  typedef logic [WB_AW-1:0] reg_addr_t;
  typedef logic [WB_DW-1:0] reg_data_t;

endpackage

// File: rtl/wb_hazard.sv
// Combinational load-use / write-cycle hazard detect; zero latency, drives stall back to decode.
// WB_BYPASS_EN adds forwarding enables and drops the write-cycle stall.
module wb_hazard
  import wb_pkg::*;
#(
  parameter int AW = WB_AW
) (
  input  wb_state_t       state,
  input  logic [AW-1:0]   ld_dst_q,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [AW-1:0]   rd_addrA,
  input  logic [AW-1:0]   rd_addrB,
`ifdef WB_BYPASS_EN
  output logic            fwdA_en,
  output logic            fwdB_en,
`endif
  output logic            stall
);

  logic load_use;
  logic wr_hit_a;
  logic wr_hit_b;

  assign load_use = ((state == WAIT) && ((rd_addrA == ld_dst_q) || (rd_addrB == ld_dst_q)))
                  || (state == HOLD);
  assign wr_hit_a = wr_en && (wr_addr == rd_addrA);
  assign wr_hit_b = wr_en && (wr_addr == rd_addrB);

`ifdef WB_BYPASS_EN
  assign fwdA_en = wr_hit_a;
  assign fwdB_en = wr_hit_b;
  assign stall   = load_use;
`else
  // Register file reads are combinational and return the old value in the write cycle.
  assign stall   = load_use || wr_hit_a || wr_hit_b;
`endif

endmodule

// File: rtl/wb_stage.sv
// Write-back arbiter of ALU results and one outstanding load; write port registered, 1 cycle after winner.
// ALU always wins the port, a colliding load is held; stall to decode is combinational (WB_BYPASS_EN adds fwd enables).
module wb_stage
  import wb_pkg::*;
#(
  parameter int DW = WB_DW,
  parameter int AW = WB_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_dst,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_dst,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  input  logic [AW-1:0] rd_addrA,
  input  logic [AW-1:0] rd_addrB,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          stall,
  output logic          ld_busy,
`ifdef WB_BYPASS_EN
  output logic          fwdA_en,
  output logic          fwdB_en,
`endif
  output logic          protocol_err
);

  wb_state_t     state, state_n;
  logic [AW-1:0] ld_dst_q, ld_dst_n;
  logic [DW-1:0] hold_q, hold_n;
  logic          kill_q, kill_n;
  logic          wr_en_n;
  logic [AW-1:0] wr_addr_n;
  logic [DW-1:0] wr_data_n;
  logic          err_n;
  logic          alu_waw;

  assign alu_waw = alu_valid && (alu_dst == ld_dst_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ld_dst_q     <= '0;
      hold_q       <= '0;
      kill_q       <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      ld_busy      <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_n;
      ld_dst_q     <= ld_dst_n;
      hold_q       <= hold_n;
      kill_q       <= kill_n;
      wr_en        <= wr_en_n;
      wr_addr      <= wr_addr_n;
      wr_data      <= wr_data_n;
      ld_busy      <= (state_n != IDLE);
      protocol_err <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    ld_dst_n  = ld_dst_q;
    hold_n    = hold_q;
    kill_n    = kill_q;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    err_n     = 1'b0;

    // The ALU owns the write port whenever it has a result.
    if (alu_valid) begin
      wr_en_n   = 1'b1;
      wr_addr_n = alu_dst;
      wr_data_n = alu_data;
    end

    case (state)
      IDLE: begin
        if (mem_rvalid) err_n = 1'b1;
        if (ld_req) begin
          ld_dst_n = ld_dst;
          kill_n   = 1'b0;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (ld_req) err_n = 1'b1;
        if (alu_waw) kill_n = 1'b1;
        if (mem_rvalid) begin
          if (alu_valid) begin
            hold_n  = mem_rdata;
            state_n = HOLD;
          end else begin
            state_n = IDLE;
            if (!kill_q) begin
              wr_en_n   = 1'b1;
              wr_addr_n = ld_dst_q;
              wr_data_n = mem_rdata;
            end
          end
        end
      end
      HOLD: begin
        if (ld_req || mem_rvalid) err_n = 1'b1;
        if (alu_waw) kill_n = 1'b1;
        if (!alu_valid) begin
          state_n = IDLE;
          if (!kill_q) begin
            wr_en_n   = 1'b1;
            wr_addr_n = ld_dst_q;
            wr_data_n = hold_q;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  wb_hazard #(.AW(AW)) u_hazard (
    .state    (state),
    .ld_dst_q (ld_dst_q),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addrA (rd_addrA),
    .rd_addrB (rd_addrB),
`ifdef WB_BYPASS_EN
    .fwdA_en  (fwdA_en),
    .fwdB_en  (fwdB_en),
`endif
    .stall    (stall)
  );

endmodule
